rename_map: RTL
===============

Name: rename_map

Overview:
- Speculative register-rename stage. Renames each dispatch group of up to N instructions by reading and updating the speculative map table, plus one ready bit per physical tag.
- Takes destination tags from the freelist (FreeReg, FreeSlotsForN) and returns the number consumed as AllocPopCount.
- Source tags, ready flags, new destination tags and displaced old tags go to the ROB and reservation stations.
- On a mispredict, restores the map from the architectural map table in one cycle.

Parameters:
- N, `N, superscalar width (lanes per dispatch group).
- PR_COUNT, `PHYS_REG_SZ_R10K, number of physical tags. PHYS_TAG width is clog2(PR_COUNT).
- ARCH_COUNT, 32, number of architectural registers. Arch reg 0 is hardwired zero.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- disp_valid  in  N  lane i holds a decoded instruction.
- disp_has_dest  in  N  lane i writes a destination register.
- disp_rd  in  N x clog2(ARCH_COUNT)  destination arch reg.
- disp_rs1, disp_rs2  in  N x clog2(ARCH_COUNT)  source arch regs.
- disp_limit  in  clog2(N+1)  max lanes downstream can take this cycle (min of ROB and RS space).
- FreeReg  in  N x PHYS_TAG  next free tags from the freelist.
- FreeSlotsForN  in  clog2(N+1)  number of valid FreeReg entries.
- AllocPopCount  out  clog2(N+1)  tags consumed this cycle.
- rename_count  out  clog2(N+1)  lanes accepted, always lanes 0..rename_count-1.
- src1_tag, src2_tag  out  N x PHYS_TAG  renamed sources.
- src1_rdy, src2_rdy  out  N  source value already available.
- dest_tag  out  N x PHYS_TAG  newly allocated tag. Tag 0 when the lane has no effective destination.
- old_tag  out  N x PHYS_TAG  previous mapping of rd, for ROB retire-time freeing.
- cdb_valid  in  N  completion broadcast valid.
- cdb_tag  in  N x PHYS_TAG  completing tags.
- BPRecoverEN  in  1  one-cycle mispredict recovery pulse.
- archi_maptable  in  ARCH_COUNT x PHYS_TAG  precise architectural map.

Behaviour:
- **State:**
  - map[ARCH_COUNT] of PHYS_TAG.
  - ready[PR_COUNT] bits.
- **Reset (async):**
  - map[r] = r for all r.
  - ready = all ones.
  - All outputs are combinational functions of state and inputs. With disp_valid = 0, every output is 0.
- **Effective dest:** eff_dest[i] = disp_has_dest[i] && disp_rd[i] != 0. Writes to x0 never allocate.
- **Acceptance (combinational, 0 latency):**
  - rename_count = largest k such that:
    - k <= disp_limit;
    - lanes 0..k-1 all have disp_valid = 1;
    - count of eff_dest among lanes 0..k-1 <= FreeSlotsForN.
  - The first invalid or unallocatable lane stops acceptance. There is no skipping.
  - AllocPopCount = number of eff_dest in the accepted prefix.
- **Tag assignment:**
  - Accepted lane i with eff_dest takes FreeReg[j], where j = number of eff_dest lanes before i.
  - Lanes outside the accepted prefix, or without eff_dest, drive dest_tag = 0.
- **Source lookup for lane i, highest priority first:**
  1. rs = 0 gives tag 0, rdy = 1.
  2. The youngest earlier accepted lane j < i with eff_dest and rd == rs gives dest_tag[j], rdy = 0.
  3. Otherwise map[rs] and ready[map[rs]], OR'd with a same-cycle CDB match on that tag.
- **old_tag[i]:**
  - Youngest earlier accepted lane with the same rd gives dest_tag[j].
  - Otherwise map[rd[i]].
  - 0 when the lane has no eff_dest.
- **Clock edge, normal operation:**
  - For each accepted eff_dest lane in order, map[rd] <= dest_tag. With duplicate rd, the youngest lane wins.
  - ready[dest_tag] <= 0 for each allocation.
  - ready[cdb_tag[k]] <= 1 for each cdb_valid[k].
  - If the same tag is allocated and broadcast in one cycle, allocation wins (ready = 0).
  - map[0] and ready[0] are never modified (stay 0 and 1).
- **Recovery:**
  - When BPRecoverEN = 1: map <= archi_maptable, ready <= all ones.
  - In that cycle rename_count = 0 and AllocPopCount = 0. Dispatch inputs are ignored and CDB updates are dropped.
- **Priority:** reset > BPRecoverEN > normal.
- **Boundaries:**
  - FreeSlotsForN = 0 still accepts leading lanes without a dest.
  - disp_limit = 0 gives rename_count = 0.
  - Reset asserted mid-group discards everything immediately.

Decomposition:
- In sys_defs.svh:
  - PHYS_TAG;
  - ARCH_REG typedef (clog2(ARCH_COUNT) bits);
  - ZERO_REG constant.
- One combinational sub-module, rename_alloc_select:
  - computes the accepted prefix, per-lane FreeReg index, rename_count and AllocPopCount;
  - takes disp_valid, eff_dest, disp_limit and FreeSlotsForN.
- The map, ready array and intra-group bypass stay in rename_map.

Test Plan (N=3, PR_COUNT=64):
- **Reset, 3 lanes, no deps:** FreeReg = {32,33,34}, lanes rd = 5, 6, 7, all valid, limit 3 -> rename_count = 3, AllocPopCount = 3, dest = 32/33/34, old = 5/6/7. Next cycle, reading x5 -> tag 32, rdy = 0.
- **Intra-group dependency:** lane0 rd = 3, lane1 rs1 = 3 and rd = 3, lane2 rs2 = 3 -> lane1 src1 = 32 rdy 0, old_tag[1] = 32. Lane2 src2 = 33. map[3] = 33 afterwards.
- **Freelist shortage:** FreeSlotsForN = 1, all three lanes have eff_dest -> rename_count = 1, AllocPopCount = 1. If lane0 has no dest: rename_count = 2, AllocPopCount = 1, lane1 gets FreeReg[0].
- **x0 handling:** rd = 0 with has_dest -> no allocation, dest_tag = 0. rs1 = 0 -> tag 0, rdy 1.
- **CDB:** cdb_tag = 32 while lane0 reads x5 (map 32) -> src1_rdy = 1 in the same cycle, and ready[32] = 1 next cycle.
- **Recovery:** after renames, pulse BPRecoverEN with archi_maptable[5] = 40 -> rename_count = 0 that cycle. Next cycle x5 -> 40, rdy 1.

Source files
------------

// File: rtl/rename_map_pkg.sv
// Shared sizes and types for the speculative rename stage.
package rename_map_pkg;

    localparam int N          = 3;
    localparam int PR_COUNT   = 64;
    localparam int ARCH_COUNT = 32;
    localparam int TAG_W      = $clog2(PR_COUNT);
    localparam int AREG_W     = $clog2(ARCH_COUNT);
    localparam int CNT_W      = $clog2(N + 1);

    typedef logic [TAG_W-1:0]  PHYS_TAG;
    typedef logic [AREG_W-1:0] ARCH_REG;
    typedef logic [CNT_W-1:0]  lane_cnt_t;

    localparam ARCH_REG ZERO_REG = '0;

    typedef struct packed {
        PHYS_TAG tag;
        logic    rdy;
    } src_t;

endpackage

// File: rtl/rename_map_if.sv
// Dispatch-group bundle between decode/freelist and the rename stage.
interface rename_map_if import rename_map_pkg::*; ();

    logic      [N-1:0] disp_valid;
    logic      [N-1:0] disp_has_dest;
    ARCH_REG   [N-1:0] disp_rd;
    ARCH_REG   [N-1:0] disp_rs1;
    ARCH_REG   [N-1:0] disp_rs2;
    lane_cnt_t         disp_limit;
    PHYS_TAG   [N-1:0] FreeReg;
    lane_cnt_t         FreeSlotsForN;

    lane_cnt_t         AllocPopCount;
    lane_cnt_t         rename_count;
    PHYS_TAG   [N-1:0] src1_tag;
    PHYS_TAG   [N-1:0] src2_tag;
    logic      [N-1:0] src1_rdy;
    logic      [N-1:0] src2_rdy;
    PHYS_TAG   [N-1:0] dest_tag;
    PHYS_TAG   [N-1:0] old_tag;

    modport master (
        output disp_valid, disp_has_dest, disp_rd, disp_rs1, disp_rs2, disp_limit,
        output FreeReg, FreeSlotsForN,
        input  AllocPopCount, rename_count, src1_tag, src2_tag, src1_rdy, src2_rdy,
        input  dest_tag, old_tag
    );

    modport slave (
        input  disp_valid, disp_has_dest, disp_rd, disp_rs1, disp_rs2, disp_limit,
        input  FreeReg, FreeSlotsForN,
        output AllocPopCount, rename_count, src1_tag, src2_tag, src1_rdy, src2_rdy,
        output dest_tag, old_tag
    );

endinterface

// File: rtl/rename_alloc_select.sv
// Picks the in-order accepted lane prefix and hands out freelist slots to it.
module rename_alloc_select import rename_map_pkg::*; (
    input  logic      [N-1:0] disp_valid,
    input  logic      [N-1:0] eff_dest,
    input  lane_cnt_t         disp_limit,
    input  lane_cnt_t         FreeSlotsForN,
    output logic      [N-1:0] accepted,
    output lane_cnt_t [N-1:0] free_idx,
    output lane_cnt_t         rename_count,
    output lane_cnt_t         AllocPopCount
);

    int   used;
    int   taken;
    logic still_open;

    // Acceptance stops at the first lane that cannot go; later lanes never skip ahead.
    always_comb begin
        used       = 0;
        taken      = 0;
        still_open = 1'b1;
        accepted   = '0;
        free_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (still_open && (i < int'(disp_limit)) && disp_valid[i] &&
                ((used + (eff_dest[i] ? 1 : 0)) <= int'(FreeSlotsForN))) begin
                accepted[i] = 1'b1;
                free_idx[i] = lane_cnt_t'(used);
                if (eff_dest[i]) begin
                    used = used + 1;
                end
                taken = taken + 1;
            end else begin
                still_open = 1'b0;
            end
        end
        rename_count  = lane_cnt_t'(taken);
        AllocPopCount = lane_cnt_t'(used);
    end

endmodule

// File: rtl/rename_map.sv
// Speculative map table plus per-tag ready bits; renames one dispatch group per cycle
// with intra-group bypass and single-cycle restore from the architectural map.
module rename_map import rename_map_pkg::*; (
    input  logic                     clock,
    input  logic                     reset_n,
    rename_map_if.slave              rn,
    input  logic    [N-1:0]          cdb_valid,
    input  PHYS_TAG [N-1:0]          cdb_tag,
    input  logic                     BPRecoverEN,
    input  PHYS_TAG [ARCH_COUNT-1:0] archi_maptable
);

    PHYS_TAG   [ARCH_COUNT-1:0] map_q, map_d;
    logic      [PR_COUNT-1:0]   ready_q, ready_d;
    logic      [N-1:0]          eff_dest;
    logic      [N-1:0]          accepted;
    lane_cnt_t [N-1:0]          free_idx;
    lane_cnt_t                  alloc_limit;
    PHYS_TAG   [N-1:0]          dest;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            eff_dest[i] = rn.disp_has_dest[i] && (rn.disp_rd[i] != ZERO_REG);
        end
    end

    // A recovery cycle accepts nothing.
    assign alloc_limit = BPRecoverEN ? '0 : rn.disp_limit;

    rename_alloc_select u_alloc_select (
        .disp_valid    (rn.disp_valid),
        .eff_dest      (eff_dest),
        .disp_limit    (alloc_limit),
        .FreeSlotsForN (rn.FreeSlotsForN),
        .accepted      (accepted),
        .free_idx      (free_idx),
        .rename_count  (rn.rename_count),
        .AllocPopCount (rn.AllocPopCount)
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            dest[i] = '0;
            if (accepted[i] && eff_dest[i]) begin
                dest[i] = rn.FreeReg[free_idx[i]];
            end
        end
    end

    assign rn.dest_tag = dest;

    function automatic logic cdb_hit(PHYS_TAG tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (cdb_valid[k] && (cdb_tag[k] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Youngest earlier lane writing rs overrides the table; x0 overrides everything.
    function automatic src_t src_lookup(int lane, ARCH_REG rs);
        src_t s;
        s.tag = map_q[rs];
        s.rdy = ready_q[map_q[rs]] | cdb_hit(map_q[rs]);
        for (int j = 0; j < N; j++) begin
            if ((j < lane) && accepted[j] && eff_dest[j] && (rn.disp_rd[j] == rs)) begin
                s.tag = dest[j];
                s.rdy = 1'b0;
            end
        end
        if (rs == ZERO_REG) begin
            s.tag = '0;
            s.rdy = 1'b1;
        end
        return s;
    endfunction

    always_comb begin
        rn.src1_tag = '0;
        rn.src2_tag = '0;
        rn.src1_rdy = '0;
        rn.src2_rdy = '0;
        rn.old_tag  = '0;
        for (int i = 0; i < N; i++) begin
            if (accepted[i]) begin
                {rn.src1_tag[i], rn.src1_rdy[i]} = src_lookup(i, rn.disp_rs1[i]);
                {rn.src2_tag[i], rn.src2_rdy[i]} = src_lookup(i, rn.disp_rs2[i]);
            end
            if (accepted[i] && eff_dest[i]) begin
                rn.old_tag[i] = map_q[rn.disp_rd[i]];
                for (int j = 0; j < N; j++) begin
                    if ((j < i) && eff_dest[j] && (rn.disp_rd[j] == rn.disp_rd[i])) begin
                        rn.old_tag[i] = dest[j];
                    end
                end
            end
        end
    end

    // Allocations are applied after CDB wakeups so a same-cycle reuse stays not-ready.
    always_comb begin
        map_d   = map_q;
        ready_d = ready_q;
        if (BPRecoverEN) begin
            map_d   = archi_maptable;
            ready_d = '1;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (cdb_valid[k]) begin
                    ready_d[cdb_tag[k]] = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (accepted[i] && eff_dest[i]) begin
                    map_d[rn.disp_rd[i]] = dest[i];
                    ready_d[dest[i]]     = 1'b0;
                end
            end
        end
        map_d[0]   = '0;
        ready_d[0] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < ARCH_COUNT; r++) begin
                map_q[r] <= PHYS_TAG'(r);
            end
            ready_q <= '1;
        end else begin
            map_q   <= map_d;
            ready_q <= ready_d;
        end
    end

endmodule
